// File: rtl/cpu_trace_emitter_if.sv
// Event-in / byte-out bus of the CPU trace line emitter.
// master: event source and byte sink side; slave: the emitter.
interface cpu_trace_emitter_if;
  logic        in_valid;
  logic        in_ready;
  logic        kind;
  logic [13:0] time_v;
  logic [31:0] pc;
  logic [4:0]  grf;
  logic [31:0] addr;
  logic [31:0] data;
  logic [7:0]  char;
  logic        char_valid;
  logic        out_ready;

  modport master (
    output in_valid, kind, time_v, pc, grf, addr, data, out_ready,
    input  in_ready, char, char_valid
  );

  modport slave (
    input  in_valid, kind, time_v, pc, grf, addr, data, out_ready,
    output in_ready, char, char_valid
  );
endinterface

// File: rtl/cpu_trace_emitter.sv
// Serialises one write-back event into "^<time>@<pc>: $<grf>|*<addr> <= <data>#", one byte per cycle.
// Build option EMIT_TIME_ZPAD_EN: time field always 4 digits with leading zeros.
module cpu_trace_emitter #(
  parameter int unsigned PAD_SP = 1
) (
  input  logic                clk,
  input  logic                reset,
  cpu_trace_emitter_if.slave  bus
);

  localparam int unsigned TIME_W = 14;
  localparam int unsigned BCD_W  = 16;
  localparam int unsigned DD_W   = BCD_W + TIME_W;
  localparam int unsigned IDX_W  = 3;
  localparam int unsigned CNT_W  = 4;

  localparam logic [CNT_W-1:0]  CONV_STEPS = CNT_W'(TIME_W);
  localparam logic [TIME_W-1:0] TIME_MAX   = TIME_W'(9999);
  localparam logic [IDX_W-1:0]  PAD_LAST   = IDX_W'(PAD_SP - 1);
  localparam logic [IDX_W-1:0]  HEX_LAST   = IDX_W'(7);
  localparam bit                HAS_PAD    = (PAD_SP != 0);

  typedef enum logic [4:0] {
    IDLE, CONV, CARET, TIME, AT, PC, COLON, SP1, TAG,
    GRF, ADDR, SP2, LT, EQ, SP3, DATA, HASH
  } state_t;

  typedef struct packed {
    logic        kind;
    logic [31:0] pc;
    logic [4:0]  grf;
    logic [31:0] addr;
    logic [31:0] data;
  } evt_t;

  state_t           state_q, state_d;
  evt_t             evt_q, evt_d;
  logic [DD_W-1:0]  dd_q, dd_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [IDX_W-1:0] idx_q, idx_d;
  logic [7:0]       char_q, char_d;
  logic             char_valid_q, char_valid_d;
  logic             in_ready_q, in_ready_d;

  logic [BCD_W-1:0] bcd;
  logic [IDX_W-1:0] time_last;
  logic [1:0]       grf_tens;
  logic [3:0]       grf_ones;
  logic [4:0]       grf_tens_x10;
  logic             load;
  logic             last;
  logic [7:0]       load_char;
  logic [TIME_W-1:0] time_sat;

  // One double-dabble step: add 3 to every BCD digit >= 5, then shift left.
  function automatic logic [DD_W-1:0] dd_step(input logic [DD_W-1:0] v);
    logic [DD_W-1:0] t;
    t = v;
    for (int i = 0; i < 4; i++) begin
      if (t[TIME_W + 4*i +: 4] >= 4'd5) t[TIME_W + 4*i +: 4] = t[TIME_W + 4*i +: 4] + 4'd3;
    end
    return {t[DD_W-2:0], 1'b0};
  endfunction

  function automatic logic [7:0] dec_char(input logic [3:0] n);
    return 8'h30 + {4'h0, n};
  endfunction

  function automatic logic [7:0] hex_char(input logic [3:0] n);
    return (n < 4'd10) ? (8'h30 + {4'h0, n}) : (8'h57 + {4'h0, n});
  endfunction

  assign bcd      = dd_q[DD_W-1 -: BCD_W];
  assign last     = (idx_q == '0);
  assign time_sat = (bus.time_v > TIME_MAX) ? TIME_MAX : bus.time_v;

  // Index of the most significant time digit to print.
  always_comb begin
`ifdef EMIT_TIME_ZPAD_EN
    time_last = IDX_W'(3);
`else
    if      (bcd[15:12] != 4'd0) time_last = IDX_W'(3);
    else if (bcd[11:8]  != 4'd0) time_last = IDX_W'(2);
    else if (bcd[7:4]   != 4'd0) time_last = IDX_W'(1);
    else                         time_last = IDX_W'(0);
`endif
  end

  always_comb begin
    if      (evt_q.grf >= 5'd30) grf_tens = 2'd3;
    else if (evt_q.grf >= 5'd20) grf_tens = 2'd2;
    else if (evt_q.grf >= 5'd10) grf_tens = 2'd1;
    else                         grf_tens = 2'd0;
    grf_tens_x10 = 5'(grf_tens) * 5'd10;
    grf_ones     = 4'(evt_q.grf - grf_tens_x10);
  end

  // Next-state: accept, convert, then advance one byte per sink transfer.
  always_comb begin
    state_d      = state_q;
    evt_d        = evt_q;
    dd_d         = dd_q;
    cnt_d        = cnt_q;
    idx_d        = idx_q;
    char_valid_d = char_valid_q;
    load         = 1'b0;

    case (state_q)
      IDLE: begin
        if (bus.in_valid) begin
          state_d = CONV;
          evt_d   = '{kind: bus.kind, pc: bus.pc, grf: bus.grf, addr: bus.addr, data: bus.data};
          dd_d    = {{BCD_W{1'b0}}, time_sat};
          cnt_d   = '0;
        end
      end
      CONV: begin
        if (cnt_q != CONV_STEPS) begin
          dd_d  = dd_step(dd_q);
          cnt_d = cnt_q + CNT_W'(1);
        end else begin
          state_d = CARET;
          load    = 1'b1;
        end
      end
      default: begin
        if (char_valid_q && bus.out_ready) begin
          load = 1'b1;
          case (state_q)
            CARET: begin state_d = TIME; idx_d = time_last; end
            TIME:  if (last) state_d = AT; else idx_d = idx_q - IDX_W'(1);
            AT:    begin state_d = PC; idx_d = HEX_LAST; end
            PC:    if (last) state_d = COLON; else idx_d = idx_q - IDX_W'(1);
            COLON: if (HAS_PAD) begin state_d = SP1; idx_d = PAD_LAST; end else state_d = TAG;
            SP1:   if (last) state_d = TAG; else idx_d = idx_q - IDX_W'(1);
            TAG: begin
              if (evt_q.kind) begin
                state_d = ADDR;
                idx_d   = HEX_LAST;
              end else begin
                state_d = GRF;
                idx_d   = (grf_tens != 2'd0) ? IDX_W'(1) : IDX_W'(0);
              end
            end
            GRF, ADDR: begin
              if (!last) idx_d = idx_q - IDX_W'(1);
              else if (HAS_PAD) begin state_d = SP2; idx_d = PAD_LAST; end
              else state_d = LT;
            end
            SP2:   if (last) state_d = LT; else idx_d = idx_q - IDX_W'(1);
            LT:    state_d = EQ;
            EQ:    if (HAS_PAD) begin state_d = SP3; idx_d = PAD_LAST; end
                   else begin state_d = DATA; idx_d = HEX_LAST; end
            SP3:   if (last) begin state_d = DATA; idx_d = HEX_LAST; end
                   else idx_d = idx_q - IDX_W'(1);
            DATA:  if (last) state_d = HASH; else idx_d = idx_q - IDX_W'(1);
            default: begin
              // '#' handed off: line complete.
              state_d      = IDLE;
              char_valid_d = 1'b0;
              load         = 1'b0;
            end
          endcase
        end
      end
    endcase

    if (load) char_valid_d = 1'b1;
    in_ready_d = (state_d == IDLE);
  end

  // Byte presented for the state/index being entered.
  always_comb begin
    load_char = 8'h00;
    case (state_d)
      CARET:         load_char = 8'h5e;
      TIME:          load_char = dec_char(bcd[{idx_d[1:0], 2'b00} +: 4]);
      AT:            load_char = 8'h40;
      PC:            load_char = hex_char(evt_q.pc[{idx_d, 2'b00} +: 4]);
      COLON:         load_char = 8'h3a;
      SP1, SP2, SP3: load_char = 8'h20;
      TAG:           load_char = evt_q.kind ? 8'h2a : 8'h24;
      GRF:           load_char = (idx_d != '0) ? dec_char({2'b00, grf_tens}) : dec_char(grf_ones);
      ADDR:          load_char = hex_char(evt_q.addr[{idx_d, 2'b00} +: 4]);
      LT:            load_char = 8'h3c;
      EQ:            load_char = 8'h3d;
      DATA:          load_char = hex_char(evt_q.data[{idx_d, 2'b00} +: 4]);
      HASH:          load_char = 8'h23;
      default:       load_char = 8'h00;
    endcase
    char_d = load ? load_char : char_q;
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q      <= IDLE;
      evt_q        <= '0;
      dd_q         <= '0;
      cnt_q        <= '0;
      idx_q        <= '0;
      char_q       <= 8'h00;
      char_valid_q <= 1'b0;
      in_ready_q   <= 1'b1;
    end else begin
      state_q      <= state_d;
      evt_q        <= evt_d;
      dd_q         <= dd_d;
      cnt_q        <= cnt_d;
      idx_q        <= idx_d;
      char_q       <= char_d;
      char_valid_q <= char_valid_d;
      in_ready_q   <= in_ready_d;
    end
  end

  assign bus.in_ready   = in_ready_q;
  assign bus.char       = char_q;
  assign bus.char_valid = char_valid_q;

endmodule

// File: tb/tb_cpu_trace_emitter.sv
// Bench for cpu_trace_emitter: PAD_SP=1 and PAD_SP=0 instances share stimulus,
// each checked every cycle against a string-level line model.
module tb_cpu_trace_emitter;

  logic clk = 1'b0;
  logic reset;
  always #5 clk = ~clk;

  cpu_trace_emitter_if if0();
  cpu_trace_emitter_if if1();

  assign if1.in_valid  = if0.in_valid;
  assign if1.kind      = if0.kind;
  assign if1.time_v    = if0.time_v;
  assign if1.pc        = if0.pc;
  assign if1.grf       = if0.grf;
  assign if1.addr      = if0.addr;
  assign if1.data      = if0.data;
  assign if1.out_ready = if0.out_ready;

  cpu_trace_emitter #(.PAD_SP(1)) dut0 (.clk(clk), .reset(reset), .bus(if0));
  cpu_trace_emitter #(.PAD_SP(0)) dut1 (.clk(clk), .reset(reset), .bus(if1));

  int    errors = 0;
  int    checks = 0;
  int    cyc = 0;
  int    tmo = 0;
  bit    done = 1'b0;
  bit    final_done = 1'b0;
  bit    pins_done = 1'b0;
  int    or_mode = 0;

  bit    busy [2];
  int    start_c [2];
  string exp_s [2];
  int    exp_i [2];

  always @(posedge clk) cyc <= cyc + 1;

  // Reference: the whole line as a string, straight from the format rules.
  function automatic string line_of(int p, bit k, logic [13:0] t, logic [31:0] pcv,
                                    logic [4:0] g, logic [31:0] a, logic [31:0] d);
    int    tt;
    string ts, sp, tag;
    tt = (int'(t) > 9999) ? 9999 : int'(t);
    ts = $sformatf("%0d", tt);
`ifdef EMIT_TIME_ZPAD_EN
    while (ts.len() < 4) ts = {"0", ts};
`endif
    sp = "";
    for (int i = 0; i < p; i++) sp = {sp, " "};
    tag = k ? {"*", $sformatf("%08h", a)} : {"$", $sformatf("%0d", g)};
    return {"^", ts, "@", $sformatf("%08h", pcv), ":", sp, tag, sp, "<=", sp,
            $sformatf("%08h", d), "#"};
  endfunction

  task automatic chk(string nm, logic [31:0] act, logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", nm, act, exp, cyc);
    end
  endtask

  task automatic chk_s(string nm, string act, string exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s: got \"%s\" expected \"%s\"", nm, act, exp);
    end
  endtask

  task automatic mon_dut(int d, logic cv, logic [7:0] ch, logic ir);
    bit    ev;
    string s;
    byte   b;
    if (reset !== 1'b1) begin
      chk($sformatf("rst_char_valid%0d", d), 32'(cv), 32'd0);
      chk($sformatf("rst_char%0d", d), 32'(ch), 32'h00);
      chk($sformatf("rst_in_ready%0d", d), 32'(ir), 32'd1);
      busy[d] = 1'b0; exp_s[d] = ""; exp_i[d] = 0;
      return;
    end
    ev = busy[d] && (cyc >= start_c[d]);
    chk($sformatf("in_ready%0d", d), 32'(ir), 32'(!busy[d]));
    chk($sformatf("char_valid%0d", d), 32'(cv), 32'(ev));
    if (ev) begin
      s = exp_s[d];
      b = s[exp_i[d]];
      chk($sformatf("char%0d[%0d]", d, exp_i[d]), 32'(ch), 32'(b));
    end
    if (!busy[d]) begin
      if (if0.in_valid) begin
        busy[d]    = 1'b1;
        exp_s[d]   = line_of((d == 0) ? 1 : 0, if0.kind, if0.time_v, if0.pc, if0.grf,
                             if0.addr, if0.data);
        exp_i[d]   = 0;
        start_c[d] = cyc + 16;
      end
    end else if (ev && if0.out_ready) begin
      exp_i[d]++;
      if (exp_i[d] >= exp_s[d].len()) busy[d] = 1'b0;
    end
  endtask

  // Single compare process, sampling on the falling edge.
  always @(negedge clk) begin
    if (!pins_done) begin
      pins_done = 1'b1;
`ifdef EMIT_TIME_ZPAD_EN
      chk_s("pin_t2", line_of(1, 0, 14'd5, 32'h3000, 5'd3, 32'h0, 32'habcd),
            "^0005@00003000: $3 <= 0000abcd#");
`else
      chk_s("pin_t2", line_of(1, 0, 14'd5, 32'h3000, 5'd3, 32'h0, 32'habcd),
            "^5@00003000: $3 <= 0000abcd#");
`endif
      chk_s("pin_t3", line_of(1, 1, 14'd1234, 32'h300c, 5'd0, 32'h10, 32'hffffffff),
            "^1234@0000300c: *00000010 <= ffffffff#");
      chk_s("pin_t5_p1", line_of(1, 0, 14'd10000, 32'h3000, 5'd31, 32'h0, 32'habcd),
            "^9999@00003000: $31 <= 0000abcd#");
      chk_s("pin_t5_p0", line_of(0, 0, 14'd10000, 32'h3000, 5'd31, 32'h0, 32'habcd),
            "^9999@00003000:$31<=0000abcd#");
    end
    mon_dut(0, if0.char_valid, if0.char, if0.in_ready);
    mon_dut(1, if1.char_valid, if1.char, if1.in_ready);
    if (done && !final_done) begin
      chk("timeouts", 32'(tmo), 32'd0);
      chk("drained0", 32'(busy[0]), 32'd0);
      chk("drained1", 32'(busy[1]), 32'd0);
      final_done = 1'b1;
    end
  end

  // Sole driver of out_ready: steady, random, or a 3-cycle stall on dut0's '@'.
  int stall = 0;
  bit stalled = 1'b0;
  always @(posedge clk) begin
    #2;
    case (or_mode)
      1: begin if0.out_ready = ($urandom_range(0, 3) != 0); stalled = 1'b0; end
      2: begin
        if (stall > 0) begin
          if0.out_ready = 1'b0; stall--;
        end else if (!stalled && if0.char_valid && if0.char == 8'h40) begin
          if0.out_ready = 1'b0; stall = 2; stalled = 1'b1;
        end else begin
          if0.out_ready = 1'b1;
        end
      end
      default: begin if0.out_ready = 1'b1; stalled = 1'b0; end
    endcase
  end

  task automatic step();
    @(posedge clk);
    #2;
  endtask

  task automatic scramble();
    if0.kind   = 1'($urandom);
    if0.time_v = 14'($urandom);
    if0.pc     = $urandom;
    if0.grf    = 5'($urandom);
    if0.addr   = $urandom;
    if0.data   = $urandom;
  endtask

  task automatic wait_idle(int budget);
    int n;
    n = 0;
    while (!(if0.in_ready && if1.in_ready) && n < budget) begin
      step();
      n++;
    end
    if (n >= budget) tmo++;
  endtask

  task automatic send(bit k, logic [13:0] t, logic [31:0] pcv, logic [4:0] g,
                      logic [31:0] a, logic [31:0] d);
    wait_idle(300);
    if0.kind = k; if0.time_v = t; if0.pc = pcv; if0.grf = g; if0.addr = a; if0.data = d;
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    scramble();
  endtask

  initial begin
    int n;
    reset = 1'b0;
    if0.in_valid = 1'b1;
    scramble();
    repeat (3) step();
    if0.in_valid = 1'b0;
    step();
    reset = 1'b1;
    step();

    send(0, 14'd5, 32'h00003000, 5'd3, 32'h0, 32'h0000abcd);
    send(1, 14'd1234, 32'h0000300c, 5'd0, 32'h00000010, 32'hffffffff);
    send(0, 14'd0, 32'h89abcdef, 5'd10, 32'h0, 32'h01234567);
    send(0, 14'd10000, 32'h00003000, 5'd31, 32'h0, 32'h0000abcd);
    send(1, 14'd16383, 32'hffffffff, 5'd0, 32'hdeadbeef, 32'h0);
    wait_idle(300);

    or_mode = 2;
    step();
    send(0, 14'd5, 32'h00003000, 5'd3, 32'h0, 32'h0000abcd);
    wait_idle(300);
    or_mode = 0;

    // Reset pulse while dut0 is emitting PC digits.
    send(0, 14'd77, 32'h12345678, 5'd7, 32'h0, 32'h55aa55aa);
    n = 0;
    while (!(if0.char_valid && if0.char == 8'h40) && n < 100) begin step(); n++; end
    if (n >= 100) tmo++;
    repeat (3) step();
    reset = 1'b0;
    if0.in_valid = 1'b1;
    step();
    if0.in_valid = 1'b0;
    reset = 1'b1;
    step();
    send(0, 14'd5, 32'h0000abcd, 5'd9, 32'h0, 32'h00000001);
    wait_idle(300);

    or_mode = 1;
    for (int i = 0; i < 3000; i++) begin
      scramble();
      case ($urandom_range(0, 3))
        0:       if0.time_v = 14'($urandom_range(0, 9));
        1:       if0.time_v = 14'($urandom_range(0, 999));
        2:       if0.time_v = 14'($urandom_range(0, 9999));
        default: if0.time_v = 14'($urandom);
      endcase
      if0.in_valid = ($urandom_range(0, 3) == 0);
      step();
    end
    if0.in_valid = 1'b0;
    wait_idle(600);
    repeat (3) step();

    done = 1'b1;
    n = 0;
    while (!final_done && n < 10) begin step(); n++; end
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
